// File: rtl/paddle_pkg.sv
// Shared scan-code constants and decoder state encoding for the paddle
// motion controller.
package paddle_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_A      = 8'h1C;
    localparam logic [7:0] SC_D      = 8'h23;
    localparam logic [7:0] SC_R      = 8'h2D;
    localparam logic [7:0] SC_LARROW = 8'h6B;
    localparam logic [7:0] SC_RARROW = 8'h74;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } dec_state_t;

endpackage

// File: rtl/ps2_key_tracker.sv
// Decodes the PS/2 make/break byte stream into held flags for the
// left/right keys, plus a same-cycle recentre strobe on make of R.
module ps2_key_tracker
    import paddle_pkg::*;
(
    input  logic       CLK100MHZ,
    input  logic       rst,
    input  logic [7:0] i_code,
    input  logic       i_code_valid,
    output logic       o_left_held,
    output logic       o_right_held,
    output logic       o_recentre
);

    dec_state_t r_state, w_state_nxt;
    logic r_a, r_d, r_la, r_ra;
    logic w_a_nxt, w_d_nxt, w_la_nxt, w_ra_nxt;
    logic r_left, r_right;

    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a     <= 1'b0;
            r_d     <= 1'b0;
            r_la    <= 1'b0;
            r_ra    <= 1'b0;
            r_left  <= 1'b0;
            r_right <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_d     <= w_d_nxt;
            r_la    <= w_la_nxt;
            r_ra    <= w_ra_nxt;
            r_left  <= w_a_nxt | w_la_nxt;
            r_right <= w_d_nxt | w_ra_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_d_nxt     = r_d;
        w_la_nxt    = r_la;
        w_ra_nxt    = r_ra;
        o_recentre  = 1'b0;
        if (i_code_valid) begin
            // Every accepted byte ends a sequence unless it is a prefix.
            w_state_nxt = ST_IDLE;
            case (r_state)
                ST_IDLE: begin
                    if (i_code == SC_EXT)      w_state_nxt = ST_EXT;
                    else if (i_code == SC_BRK) w_state_nxt = ST_BRK;
                    else if (i_code == SC_A)   w_a_nxt     = 1'b1;
                    else if (i_code == SC_D)   w_d_nxt     = 1'b1;
                    else if (i_code == SC_R)   o_recentre  = 1'b1;
                end
                ST_BRK: begin
                    if (i_code == SC_A)      w_a_nxt = 1'b0;
                    else if (i_code == SC_D) w_d_nxt = 1'b0;
                end
                ST_EXT: begin
                    if (i_code == SC_BRK)         w_state_nxt = ST_EXT_BRK;
                    else if (i_code == SC_LARROW) w_la_nxt    = 1'b1;
                    else if (i_code == SC_RARROW) w_ra_nxt    = 1'b1;
                end
                ST_EXT_BRK: begin
                    if (i_code == SC_LARROW)      w_la_nxt = 1'b0;
                    else if (i_code == SC_RARROW) w_ra_nxt = 1'b0;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign o_left_held  = r_left;
    assign o_right_held = r_right;

endmodule

// File: rtl/paddle_motion_ctrl.sv
// Paddle x-position sequencer: key-held tracking drives a clamped step
// on every motion tick, with an immediate recentre on the R key.
module paddle_motion_ctrl
    import paddle_pkg::*;
#(
    parameter int STEP_DIV = 1_000_000,
    parameter int STEP     = 1,
    parameter int X_MIN    = 20,
    parameter int X_MAX    = 600,
    parameter int X_INIT   = 320
) (
    input  logic       CLK100MHZ,
    input  logic       rst,
    input  logic [7:0] code,
    input  logic       code_valid,
    output logic [9:0] x_pos,
    output logic       left_held,
    output logic       right_held,
    output logic       pos_changed
);

    localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);
    localparam logic signed [10:0] P_STEP = 11'(STEP);
    localparam logic signed [10:0] P_MIN  = 11'(X_MIN);
    localparam logic signed [10:0] P_MAX  = 11'(X_MAX);
    localparam logic [9:0]         P_INIT = 10'(X_INIT);

    logic [CNT_W-1:0]   r_cnt;
    logic               w_tick;
    logic               w_recentre;
    logic [9:0]         r_x, w_x_nxt;
    logic               r_pos_changed;
    logic signed [10:0] w_x_s, w_dn, w_up;

    ps2_key_tracker u_keys (
        .CLK100MHZ    (CLK100MHZ),
        .rst          (rst),
        .i_code       (code),
        .i_code_valid (code_valid),
        .o_left_held  (left_held),
        .o_right_held (right_held),
        .o_recentre   (w_recentre)
    );

    assign w_tick = (r_cnt == '0);

    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst)                    r_cnt <= '0;
        else if (r_cnt == CNT_LAST) r_cnt <= '0;
        else                        r_cnt <= r_cnt + 1'b1;
    end

    // 11-bit signed keeps the left step from wrapping past zero.
    always_comb begin
        w_x_s   = $signed({1'b0, r_x});
        w_dn    = w_x_s - P_STEP;
        w_up    = w_x_s + P_STEP;
        w_x_nxt = r_x;
        if (w_recentre)
            w_x_nxt = P_INIT;
        else if (w_tick && left_held && !right_held)
            w_x_nxt = (w_dn < P_MIN) ? P_MIN[9:0] : w_dn[9:0];
        else if (w_tick && right_held && !left_held)
            w_x_nxt = (w_up > P_MAX) ? P_MAX[9:0] : w_up[9:0];
    end

    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            r_x           <= P_INIT;
            r_pos_changed <= 1'b0;
        end else begin
            r_x           <= w_x_nxt;
            r_pos_changed <= (w_x_nxt != r_x);
        end
    end

    assign x_pos       = r_x;
    assign pos_changed = r_pos_changed;

endmodule

// File: tb/tb_paddle_motion_ctrl.sv
// Directed bench for paddle_motion_ctrl with STEP_DIV=10; ticks are consumed
// at edges k where k%10==1, counting edges from reset release.
module tb_paddle_motion_ctrl;

    logic       CLK100MHZ;
    logic       rst;
    logic [7:0] code;
    logic       code_valid;
    logic [9:0] x_pos;
    logic       left_held, right_held, pos_changed;

    int vectors = 0;
    int errs    = 0;
    int pulses  = 0;
    int xmax    = 0;

    paddle_motion_ctrl #(
        .STEP_DIV (10),
        .STEP     (1),
        .X_MIN    (20),
        .X_MAX    (600),
        .X_INIT   (320)
    ) dut (
        .CLK100MHZ   (CLK100MHZ),
        .rst         (rst),
        .code        (code),
        .code_valid  (code_valid),
        .x_pos       (x_pos),
        .left_held   (left_held),
        .right_held  (right_held),
        .pos_changed (pos_changed)
    );

    initial CLK100MHZ = 1'b0;
    always #5 CLK100MHZ = ~CLK100MHZ;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; presents one byte for exactly one edge.
    task automatic send(input logic [7:0] b);
        code       = b;
        code_valid = 1'b1;
        @(posedge CLK100MHZ);
        #1;
        code_valid = 1'b0;
        code       = 8'h00;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK100MHZ);
            #1;
            if (pos_changed) pulses++;
            if (int'(x_pos) > xmax) xmax = int'(x_pos);
        end
    endtask

    initial begin
        rst        = 1'b1;
        code       = 8'h00;
        code_valid = 1'b0;
        repeat (3) @(posedge CLK100MHZ);
        #1;
        rst = 1'b0;                       // edge index 0 is the one just passed

        check("reset_x",     x_pos, 320);
        check("reset_left",  left_held, 0);
        check("reset_right", right_held, 0);
        check("reset_pc",    pos_changed, 0);

        // 1: A press (repeated make is idempotent), ticks at 11,21,31
        send(8'h1C);
        check("a_make_left", left_held, 1);
        check("a_make_x",    x_pos, 320);
        send(8'h1C);
        pulses = 0;
        run(29);
        check("t1_x",      x_pos, 317);
        check("t1_pulses", pulses, 3);
        check("t1_left",   left_held, 1);

        // 2: release A, ticks at 41,51 do nothing
        send(8'hF0);
        send(8'h1C);
        pulses = 0;
        run(20);
        check("t2_left",   left_held, 0);
        check("t2_x",      x_pos, 317);
        check("t2_pulses", pulses, 0);

        // 3: hold D for 400 ticks, saturate at 600 after 283 steps
        send(8'h23);
        check("t3_right", right_held, 1);
        pulses = 0;
        xmax   = 0;
        run(4000);
        check("t3_x",      x_pos, 600);
        check("t3_xmax",   xmax, 600);
        check("t3_pulses", pulses, 283);
        send(8'hF0);
        send(8'h23);
        check("t3_release", right_held, 0);

        // 4: left arrow moves left, adding D stalls, releasing arrow resumes right
        send(8'hE0);
        send(8'h6B);
        run(50);
        check("t4_la_x",    x_pos, 595);
        check("t4_la_left", left_held, 1);
        send(8'h23);
        pulses = 0;
        run(50);
        check("t4_both_x",      x_pos, 595);
        check("t4_both_pulses", pulses, 0);
        send(8'hE0);
        send(8'hF0);
        send(8'h6B);
        pulses = 0;
        run(30);
        check("t4_resume_x",      x_pos, 598);
        check("t4_resume_pulses", pulses, 3);
        check("t4_resume_left",   left_held, 0);
        check("t4_resume_right",  right_held, 1);

        // 5: walk left down to 100, then recentre on a tick edge while A held
        send(8'hF0);
        send(8'h23);
        send(8'h1C);
        pulses = 0;
        run(4976);
        check("t5_x100",   x_pos, 100);
        check("t5_pulses", pulses, 498);
        run(9);
        send(8'h2D);                      // sampled at edge 9181, a tick edge
        check("t5_recentre_x",  x_pos, 320);
        check("t5_recentre_pc", pos_changed, 1);
        run(1);
        check("t5_pc_single", pos_changed, 0);
        check("t5_x_hold",    x_pos, 320);
        send(8'hF0);
        send(8'h1C);
        send(8'h2D);
        check("t5_same_pc",  pos_changed, 0);
        check("t5_same_x",   x_pos, 320);
        check("t5_released", left_held, 0);

        // 6: reset after E0 drops the prefix; 6B from IDLE is ignored
        send(8'hE0);
        rst = 1'b1;
        @(posedge CLK100MHZ);
        #1;
        rst = 1'b0;
        send(8'h6B);
        check("t6_left",  left_held, 0);
        check("t6_right", right_held, 0);
        pulses = 0;
        run(30);
        check("t6_x",      x_pos, 320);
        check("t6_pulses", pulses, 0);
        check("t6_left2",  left_held, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
